// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table sweep controller.
package tt_pkg;

    localparam int N_IN_DEF = 7;
    localparam int TT_W_DEF = 1 << N_IN_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Minterm index at the default input count.
    typedef logic [N_IN_DEF-1:0] minterm_t;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_lat_pipe.sv
// Delay line carrying {valid, minterm index} alongside the function under test,
// so each FUT response is paired with the minterm that produced it.
module tt_lat_pipe #(
    parameter int W     = 7,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_index,
    output logic         out_valid,
    output logic [W-1:0] out_index
);

    generate
        if (DEPTH == 0) begin : g_pass
            // A combinational FUT answers in the same cycle: nothing to delay.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, flush};
            assign out_valid   = in_valid;
            assign out_index   = in_index;
        end else begin : g_pipe
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic         v_reg;
                logic [W-1:0] i_reg;
                logic         v_in;
                logic [W-1:0] i_in;

                if (gi == 0) begin : g_head
                    assign v_in = in_valid;
                    assign i_in = in_index;
                end else begin : g_tail
                    assign v_in = g_stage[gi-1].v_reg;
                    assign i_in = g_stage[gi-1].i_reg;
                end

                always_ff @(posedge clk) begin
                    if (!rst_n || flush) begin
                        v_reg <= 1'b0;
                        i_reg <= '0;
                    end else begin
                        v_reg <= v_in;
                        i_reg <= i_in;
                    end
                end
            end
            assign out_valid = g_stage[DEPTH-1].v_reg;
            assign out_index = g_stage[DEPTH-1].i_reg;
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every minterm into a boolean network, captures its truth table,
// popcounts it and compares it against an expected table.
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int  N_IN    = N_IN_DEF,
    parameter int  DUT_LAT = 0,
    localparam int TT_W    = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] tt_exp_i,
    input  logic            f_i,
    output logic [N_IN-1:0] x_o,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt_o,
    output logic            tt_valid,
    output logic [N_IN:0]   ones_o,
    output logic            match_o
);

    localparam logic [N_IN-1:0] X_LAST     = '1;
    localparam int              OW         = N_IN + 1;
    localparam int              CNT_W      = $clog2(DUT_LAT + 2);
    localparam int              DRAIN_LAST = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;

    state_t            state;
    logic [CNT_W-1:0]  drain_cnt;
    logic              cap_valid;
    logic [N_IN-1:0]   cap_index;
    logic              cap_en;
    logic              finish;
    logic [TT_W-1:0]   tt_next;
    logic [N_IN:0]     ones_next;

    tt_lat_pipe #(
        .W     (N_IN),
        .DEPTH (DUT_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (state == ST_DRIVE),
        .in_index  (x_o),
        .out_valid (cap_valid),
        .out_index (cap_index)
    );

    // The compare at completion must see the final sample captured on that same edge.
    always_comb begin
        cap_en    = cap_valid && !abort;
        tt_next   = tt_o;
        ones_next = ones_o;
        if (cap_en) begin
            tt_next[cap_index] = f_i;
            ones_next          = ones_o + OW'(f_i);
        end
        finish = !abort &&
                 (((state == ST_DRIVE) && (x_o == X_LAST) && (DUT_LAT == 0)) ||
                  ((state == ST_DRAIN) && (drain_cnt == CNT_W'(DRAIN_LAST))));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            x_o       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt_o      <= '0;
            tt_valid  <= 1'b0;
            ones_o    <= '0;
            match_o   <= 1'b0;
        end else begin
            done   <= 1'b0;
            tt_o   <= tt_next;
            ones_o <= ones_next;
            if (finish) begin
                state    <= ST_DONE;
                x_o      <= '0;
                busy     <= 1'b0;
                done     <= 1'b1;
                tt_valid <= 1'b1;
                match_o  <= (tt_next == tt_exp_i);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state    <= ST_DRIVE;
                            x_o      <= '0;
                            busy     <= 1'b1;
                            tt_o     <= '0;
                            ones_o   <= '0;
                            tt_valid <= 1'b0;
                            match_o  <= 1'b0;
                        end
                    end
                    ST_DRIVE: begin
                        if (abort) begin
                            state <= ST_IDLE;
                            x_o   <= '0;
                            busy  <= 1'b0;
                        end else if (x_o == X_LAST) begin
                            // Terminal minterm: leave DRIVE rather than wrap.
                            state     <= ST_DRAIN;
                            x_o       <= '0;
                            drain_cnt <= '0;
                        end else begin
                            x_o <= x_o + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (abort) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: a combinational-FUT instance and a 2-cycle-latency instance.
module tb_tt_sweep_ctrl;
    import tt_pkg::*;

    localparam int TW = TT_W_DEF;

    typedef struct {
        int            fsel;
        int            lat;
        logic [TW-1:0] rnd;
        logic [TW-1:0] expv;
        logic [TW-1:0] tt;
        int            ones;
        logic          match;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, sel_b;
    int            fsel;
    logic [TW-1:0] rnd, tt_exp;

    logic          start_a, abort_a, f_a, busy_a, done_a, tv_a, match_a;
    logic          start_b, abort_b, f_b, busy_b, done_b, tv_b, match_b;
    minterm_t      x_a, x_b;
    logic [TW-1:0] tt_a, tt_b;
    logic [7:0]    ones_a, ones_b;
    logic          fb1, fb2;

    minterm_t      cx;
    logic          cbusy, cdone, ctv, cmatch;
    logic [TW-1:0] ctt;
    logic [7:0]    cones;

    int n_vec = 0;
    int n_miss = 0;
    int done_at, done_cnt, busy_cnt, x_err;
    vec_t tbl[8];

    // Functions under test: 0 = x0 buffer, 1 = 7-input AND, 3 = maj(x0,x1,x2), else table lookup.
    function automatic logic fut_eval(input int sel, input logic [TW-1:0] tb, input minterm_t x);
        case (sel)
            0:       return x[0];
            1:       return &x;
            3:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            default: return tb[x];
        endcase
    endfunction

    assign start_a = start && !sel_b;
    assign abort_a = abort && !sel_b;
    assign start_b = start && sel_b;
    assign abort_b = abort && sel_b;
    assign f_a     = fut_eval(fsel, rnd, x_a);
    assign f_b     = fb2;

    always_ff @(posedge clk) begin
        fb1 <= fut_eval(fsel, rnd, x_b);
        fb2 <= fb1;
    end

    always_comb begin
        cx     = sel_b ? x_b     : x_a;
        cbusy  = sel_b ? busy_b  : busy_a;
        cdone  = sel_b ? done_b  : done_a;
        ctv    = sel_b ? tv_b    : tv_a;
        cmatch = sel_b ? match_b : match_a;
        ctt    = sel_b ? tt_b    : tt_a;
        cones  = sel_b ? ones_b  : ones_a;
    end

    tt_sweep_ctrl #(.N_IN(N_IN_DEF), .DUT_LAT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .tt_exp_i(tt_exp),
        .f_i(f_a), .x_o(x_a), .busy(busy_a), .done(done_a), .tt_o(tt_a),
        .tt_valid(tv_a), .ones_o(ones_a), .match_o(match_a)
    );

    tt_sweep_ctrl #(.N_IN(N_IN_DEF), .DUT_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .tt_exp_i(tt_exp),
        .f_i(f_b), .x_o(x_b), .busy(busy_b), .done(done_b), .tt_o(tt_b),
        .tt_valid(tv_b), .ones_o(ones_b), .match_o(match_b)
    );

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    // Start a sweep at the next edge, then watch nk cycles; cycle k is sampled at the k-th negedge.
    task automatic run(input int nk, input int pulse_at, input int abort_at,
                       input int rst_at, input bit start_at_done);
        done_at = -1; done_cnt = 0; busy_cnt = 0; x_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= nk; k++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst_n = 1'b1;
            if (cbusy) begin
                busy_cnt++;
                if (int'(cx) != ((k <= TW) ? k - 1 : 0)) x_err++;
            end
            if (cdone) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
                if (start_at_done) start = 1'b1;
            end
            if (k == pulse_at) start = 1'b1;
            if (k == abort_at) abort = 1'b1;
            if (k == rst_at)   rst_n = 1'b0;
            if (k == abort_at + 1) begin
                chk("abort_busy_next", cbusy, 0);
                chk("abort_valid_next", ctv, 0);
            end
            if (k == rst_at + 1) begin
                chk("rst_x", cx, 0);
                chk("rst_busy", cbusy, 0);
                chk("rst_done", cdone, 0);
                chk("rst_tt", ctt, 0);
                chk("rst_valid", ctv, 0);
                chk("rst_ones", cones, 0);
                chk("rst_match", cmatch, 0);
            end
        end
        start = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int pulse_at, input bit start_at_done);
        sel_b  = (v.lat != 0);
        fsel   = v.fsel;
        rnd    = v.rnd;
        tt_exp = v.expv;
        run(140 + v.lat, pulse_at, -1, -1, start_at_done);
        chk("done_cycle", done_at, 129 + v.lat);
        chk("done_count", done_cnt, 1);
        chk("busy_cycles", busy_cnt, 128 + v.lat);
        chk("x_sequence_errors", x_err, 0);
        chk("tt", ctt, v.tt);
        chk("ones", cones, v.ones);
        chk("match", cmatch, v.match);
        chk("tt_valid", ctv, 1);
    endtask

    initial begin
        int pos;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel_b = 1'b0;
        fsel = 0; rnd = '0; tt_exp = '0;

        tbl[0] = '{fsel: 0, lat: 0, rnd: '0, expv: {32{4'hA}}, tt: {32{4'hA}}, ones: 64, match: 1'b1};
        tbl[1] = '{fsel: 1, lat: 0, rnd: '0, expv: '0, tt: {1'b1, 127'b0}, ones: 1, match: 1'b0};
        tbl[6] = '{fsel: 3, lat: 2, rnd: '0, expv: {16{8'hE8}}, tt: {16{8'hE8}}, ones: 64, match: 1'b1};
        // Random functions: reference table is the function evaluated at every minterm.
        for (int r = 2; r < 8; r++) begin
            if (r == 6) continue;
            tbl[r].fsel = 2;
            tbl[r].lat  = (r == 7) ? 2 : 0;
            tbl[r].rnd  = {$urandom, $urandom, $urandom, $urandom};
            tbl[r].ones = 0;
            for (int j = 0; j < TW; j++) begin
                tbl[r].tt[j] = fut_eval(2, tbl[r].rnd, minterm_t'(j));
                tbl[r].ones += int'(tbl[r].tt[j]);
            end
            tbl[r].expv = tbl[r].tt;
            if ($urandom_range(0, 1) == 1) begin
                pos = int'($urandom_range(0, TW - 1));
                tbl[r].expv[pos] = ~tbl[r].expv[pos];
            end
            tbl[r].match = (tbl[r].tt == tbl[r].expv);
        end

        repeat (3) @(negedge clk);
        chk("init_x", x_a, 0);
        chk("init_busy", busy_a, 0);
        chk("init_done", done_a, 0);
        chk("init_tt", tt_a, 0);
        chk("init_valid", tv_a, 0);
        chk("init_ones", ones_a, 0);
        chk("init_match", match_a, 0);
        chk("init_busy_lat2", busy_b, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) apply(tbl[i], -1, 1'b0);

        // start pulses mid-sweep and in the DONE cycle must be ignored
        apply(tbl[0], 11, 1'b1);

        // abort while x_o = 50, then a clean rerun
        sel_b = 1'b0; fsel = 0; tt_exp = tbl[0].expv;
        run(140, -1, 51, -1, 1'b0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_busy_cycles", busy_cnt, 51);
        chk("abort_valid_after", ctv, 0);
        apply(tbl[0], -1, 1'b0);

        // reset mid-sweep at x_o = 70, then start blocked by abort in IDLE
        run(100, -1, -1, 71, 1'b0);
        chk("rst_no_done", done_cnt, 0);
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", cbusy, 0);
        repeat (4) @(negedge clk);
        chk("start_abort_busy_later", cbusy, 0);
        chk("start_abort_x", cx, 0);
        chk("start_abort_done", cdone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
